// File: rtl/divisor_arb_pkg.sv
// divisor_arb_pkg: shared types and helpers for divisor_arbiter and its round-robin sub-block.
package divisor_arb_pkg;
    localparam int MAX_ID_W = 8;
    localparam int COORD_W  = 16;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic                dbz;
        logic [COORD_W-1:0]  row;
        logic [COORD_W-1:0]  col;
    } arb_tag_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/divisor_arbiter_rr_arbiter.sv
// rr_arbiter: N-way round-robin grant; the pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    grant_onehot,
    output logic [ID_W-1:0] grant_id
);
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] k;
    logic            hit;

    // Scan from the farthest candidate back to rr_ptr so the nearest valid requester wins.
    always_comb begin
        grant_id = '0;
        hit      = 1'b0;
        k        = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = ID_W'((int'(rr_ptr) + i) % N);
            if (req[k]) begin
                grant_id = k;
                hit      = 1'b1;
            end
        end
    end

    assign grant_onehot = (en && hit) ? (N'(1) << grant_id) : '0;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            rr_ptr <= '0;
        else if (en && hit)
            rr_ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
endmodule

// File: rtl/divisor_arbiter.sv
// divisor_arbiter: shares one pipelined divider among N_REQ requesters and routes tagged quotients back.
// Optional DIVISOR_ARB_DBZ_EN: zero divisors bypass the divider and return all-ones with res_dbz_o set.
module divisor_arbiter
    import divisor_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int A_WIDTH        = 16,
    parameter int B_WIDTH        = 16,
    parameter int Q_LENGTH       = 16,
    parameter int CLKS_PER_PIXEL = 1,
    parameter int DIV_LATENCY    = 18
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ-1:0][A_WIDTH-1:0]    req_a_i,
    input  logic [N_REQ-1:0][B_WIDTH-1:0]    req_b_i,
    input  logic [N_REQ-1:0]                 req_a_signed_i,
    input  logic [N_REQ-1:0]                 req_b_signed_i,
    input  logic [N_REQ-1:0][COORD_W-1:0]    req_row_i,
    input  logic [N_REQ-1:0][COORD_W-1:0]    req_col_i,
    output logic                             div_valid_o,
    output logic [A_WIDTH-1:0]               div_a_o,
    output logic [B_WIDTH-1:0]               div_b_o,
    output logic                             div_a_signed_o,
    output logic                             div_b_signed_o,
    output logic [COORD_W-1:0]               div_row_o,
    output logic [COORD_W-1:0]               div_col_o,
    input  logic                             div_valid_i,
    input  logic [Q_LENGTH:0]                div_q_i,
    output logic                             res_valid_o,
    output logic [$clog2(N_REQ)-1:0]         res_id_o,
    output logic [Q_LENGTH:0]                res_q_o,
    output logic [COORD_W-1:0]               res_row_o,
    output logic [COORD_W-1:0]               res_col_o,
    output logic                             res_dbz_o,
    output logic                             err_o
);
    localparam int ID_W   = id_width(N_REQ);
    localparam int SLOT_W = id_width(CLKS_PER_PIXEL);

    logic [SLOT_W-1:0] slot_cnt;
    logic              slot_open, accept, acc_dbz, exp_valid;
    logic [N_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]   grant_id;
    arb_tag_t          iss_tag, head;
    arb_tag_t          tag_line [DIV_LATENCY];

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req          (req_valid_i),
        .en           (slot_open),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id)
    );

    assign slot_open   = (slot_cnt == '0);
    assign req_ready_o = grant_onehot;
    assign accept      = |grant_onehot;
`ifdef DIVISOR_ARB_DBZ_EN
    assign acc_dbz = (req_b_i[grant_id] == '0);
`else
    assign acc_dbz = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            slot_cnt <= '0;
        else if (accept)
            slot_cnt <= (CLKS_PER_PIXEL > 1) ? SLOT_W'(1) : '0;
        else if (!slot_open)
            slot_cnt <= (slot_cnt == SLOT_W'(CLKS_PER_PIXEL - 1)) ? '0 : slot_cnt + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            div_valid_o    <= 1'b0;
            div_a_o        <= '0;
            div_b_o        <= '0;
            div_a_signed_o <= 1'b0;
            div_b_signed_o <= 1'b0;
            div_row_o      <= '0;
            div_col_o      <= '0;
            iss_tag        <= '0;
        end else begin
            div_valid_o <= accept & ~acc_dbz;
            iss_tag     <= accept ? arb_tag_t'{1'b1, MAX_ID_W'(grant_id), acc_dbz,
                                               req_row_i[grant_id], req_col_i[grant_id]} : '0;
            if (accept) begin
                div_a_o        <= req_a_i[grant_id];
                div_b_o        <= req_b_i[grant_id];
                div_a_signed_o <= req_a_signed_i[grant_id];
                div_b_signed_o <= req_b_signed_i[grant_id];
                div_row_o      <= req_row_i[grant_id];
                div_col_o      <= req_col_i[grant_id];
            end
        end

    // The tag enters one cycle after the issue strobe, so the head lines up with div_valid_i.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            for (int i = 0; i < DIV_LATENCY; i++)
                tag_line[i] <= '0;
        end else begin
            tag_line[0] <= iss_tag;
            for (int i = 1; i < DIV_LATENCY; i++)
                tag_line[i] <= tag_line[i-1];
        end

    assign head      = tag_line[DIV_LATENCY-1];
    assign exp_valid = head.valid & ~head.dbz;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            res_valid_o <= 1'b0;
            res_id_o    <= '0;
            res_q_o     <= '0;
            res_row_o   <= '0;
            res_col_o   <= '0;
            res_dbz_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            res_valid_o <= head.valid;
            if (head.valid) begin
                res_id_o  <= head.id[ID_W-1:0];
                res_q_o   <= head.dbz ? '1 : div_q_i;
                res_row_o <= head.row;
                res_col_o <= head.col;
                res_dbz_o <= head.dbz;
            end
            if (div_valid_i != exp_valid)
                err_o <= 1'b1;
        end
endmodule

// File: tb/tb_divisor_arbiter.sv
// tb_divisor_arbiter: directed checks of arbitration, pacing, tag return, dbz and error handling.
module tb_divisor_arbiter;
    localparam int N   = 4;
    localparam int LAT = 18;

    logic clk_i, rst_i, inject;
    logic [N-1:0] req_valid_i, req_valid3, req_a_signed_i, req_b_signed_i;
    logic [N-1:0][15:0] req_a_i, req_b_i, req_row_i, req_col_i;
    logic [N-1:0] req_ready_o, ready3;
    logic div_valid_o, div_a_signed_o, div_b_signed_o, div_valid_i;
    logic [15:0] div_a_o, div_b_o, div_row_o, div_col_o;
    logic [16:0] div_q_i, res_q_o;
    logic res_valid_o, res_dbz_o, err_o;
    logic [1:0] res_id_o;
    logic [15:0] res_row_o, res_col_o;
    logic dv3, das3, dbs3, rv3, rdbz3, err3;
    logic [15:0] da3, db3, drow3, dcol3, rrow3, rcol3;
    logic [16:0] rq3;
    logic [1:0] rid3;
    logic [LAT-1:0] pv;
    logic [16:0] pq [LAT];
    int checks, errors;
    logic seen;

    divisor_arbiter u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_a_signed_i(req_a_signed_i),
        .req_b_signed_i(req_b_signed_i), .req_row_i(req_row_i), .req_col_i(req_col_i),
        .div_valid_o(div_valid_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_a_signed_o(div_a_signed_o), .div_b_signed_o(div_b_signed_o),
        .div_row_o(div_row_o), .div_col_o(div_col_o), .div_valid_i(div_valid_i),
        .div_q_i(div_q_i), .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_q_o(res_q_o),
        .res_row_o(res_row_o), .res_col_o(res_col_o), .res_dbz_o(res_dbz_o), .err_o(err_o)
    );

    divisor_arbiter #(.CLKS_PER_PIXEL(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid3), .req_ready_o(ready3),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_a_signed_i(req_a_signed_i),
        .req_b_signed_i(req_b_signed_i), .req_row_i(req_row_i), .req_col_i(req_col_i),
        .div_valid_o(dv3), .div_a_o(da3), .div_b_o(db3), .div_a_signed_o(das3),
        .div_b_signed_o(dbs3), .div_row_o(drow3), .div_col_o(dcol3), .div_valid_i(1'b0),
        .div_q_i(17'd0), .res_valid_o(rv3), .res_id_o(rid3), .res_q_o(rq3),
        .res_row_o(rrow3), .res_col_o(rcol3), .res_dbz_o(rdbz3), .err_o(err3)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural divider: truncating division, all-ones on a zero divisor, LAT-cycle pipeline.
    function automatic logic [16:0] div_model(input logic [15:0] a, b, input logic as, bs);
        longint sa, sb;
        sa = as ? longint'($signed(a)) : longint'(a);
        sb = bs ? longint'($signed(b)) : longint'(b);
        return (sb == 0) ? 17'h1FFFF : 17'(sa / sb);
    endfunction

    always @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) pq[i] <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], div_valid_o};
            pq[0] <= div_model(div_a_o, div_b_o, div_a_signed_o, div_b_signed_o);
            for (int i = 1; i < LAT; i++) pq[i] <= pq[i-1];
        end

    assign div_valid_i = pv[LAT-1] | inject;
    assign div_q_i     = pq[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic single(input int k, input logic iss, input logic [16:0] q, input logic dbz);
        req_valid_i = N'(1) << k;
        #1;
        chk("single_ready", req_ready_o, N'(1) << k);
        step();
        req_valid_i = '0;
        chk("single_issue", div_valid_o, iss);
        step(18);
        chk("single_early", res_valid_o, 0);
        step();
        chk("single_valid", res_valid_o, 1);
        chk("single_id", res_id_o, k);
        chk("single_q", res_q_o, q);
        chk("single_dbz", res_dbz_o, dbz);
        chk("single_row", res_row_o, req_row_i[k]);
        chk("single_col", res_col_o, req_col_i[k]);
        step();
        chk("single_pulse", res_valid_o, 0);
        chk("single_hold_q", res_q_o, q);
        chk("single_err", err_o, 0);
    endtask

    initial begin
        checks = 0; errors = 0; inject = 1'b0; rst_i = 1'b1;
        req_valid_i = '0; req_valid3 = '0; req_a_signed_i = '0; req_b_signed_i = '0;
        for (int k = 0; k < N; k++) begin
            req_a_i[k]   = 16'(100 + 10 * k);
            req_b_i[k]   = 16'd5;
            req_row_i[k] = 16'(16'h10 + k);
            req_col_i[k] = 16'(16'h20 + k);
        end
        step(2);
        chk("rst_div_valid", div_valid_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_dbz", res_dbz_o, 0);
        chk("rst_q", res_q_o, 0);
        chk("rst_div_a", div_a_o, 0);
        chk("rst_ready", req_ready_o, 0);
        rst_i = 1'b0;
        step();

        // Paced instance: accepts every third cycle, alternating 0 and 1.
        req_valid3 = 4'b0011;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("pace_ready", ready3, (i % 3 != 0) ? 0 : (((i / 3) % 2) != 0 ? 2 : 1));
            step();
        end
        req_valid3 = '0;

        // All four requesters valid: accepts 0,1,2,3,0 back to back.
        req_valid_i = '1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_ready", req_ready_o, 1 << (i % 4));
            step();
            chk("rr_issue", div_valid_o, 1);
            chk("rr_div_a", div_a_o, 100 + 10 * (i % 4));
            chk("rr_div_row", div_row_o, 16'h10 + (i % 4));
        end
        req_valid_i = '0;
        #1;
        chk("rr_idle_ready", req_ready_o, 0);
        step();
        chk("rr_idle_issue", div_valid_o, 0);
        step(13);
        chk("rr_early", res_valid_o, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("rr_res_valid", res_valid_o, 1);
            chk("rr_res_id", res_id_o, i % 4);
            chk("rr_res_q", res_q_o, 20 + 2 * (i % 4));
            step();
        end
        chk("rr_res_end", res_valid_o, 0);
        chk("rr_err", err_o, 0);

        req_a_i[2] = 16'd100; req_b_i[2] = 16'd7; req_row_i[2] = 16'h0123; req_col_i[2] = 16'h0456;
        single(2, 1'b1, 17'd14, 1'b0);

        req_a_i[3] = 16'hFF9C; req_b_i[3] = 16'd7; req_a_signed_i[3] = 1'b1; req_b_signed_i[3] = 1'b1;
        single(3, 1'b1, 17'h1FFF2, 1'b0);

        req_a_i[1] = 16'd5; req_b_i[1] = 16'd0;
`ifdef DIVISOR_ARB_DBZ_EN
        single(1, 1'b0, 17'h1FFFF, 1'b1);
`else
        single(1, 1'b1, 17'h1FFFF, 1'b0);
`endif

        // Spurious divider result with an empty tag line.
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("spur_err", err_o, 1);
        chk("spur_dropped", res_valid_o, 0);
        step(3);
        chk("spur_sticky", err_o, 1);

        // Reset mid-flight clears the error and drops the in-flight tag.
        req_valid_i = 4'b0001;
        step();
        req_valid_i = '0;
        step(5);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_issue", div_valid_o, 0);
        step();
        rst_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            seen |= res_valid_o;
            step();
        end
        chk("mid_rst_no_result", seen, 0);
        chk("mid_rst_err_clear", err_o, 0);
        req_valid_i = '1;
        #1;
        chk("mid_rst_ptr", req_ready_o, 4'b0001);
        req_valid_i = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
